hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Hazard sequencer for the 5-stage pipeline (F/D/E/M/W).
- Keeps its own shadow pipeline of in-flight destination registers: per-stage valid, RegWrite, MemtoReg, destination and sources.
- From that state it drives the pipeline-register stall/flush controls and the E-stage SrcA/SrcB forwarding selects.
- Sits beside the four pipeline registers; branches resolve in M.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- RsD  in  REG_ADDR_W  Instruction[25:21] in D.
- RtD  in  REG_ADDR_W  Instruction[20:16] in D.
- RdD  in  REG_ADDR_W  Instruction[15:11] in D.
- RegWriteD  in  1  decoder output.
- MemtoRegD  in  1  decoder output.
- RegDstD  in  1  decoder output.
- BranchTakenM  in  1  ZeroFlagM AND BranchM.
- StallF  out  1  hold PC.
- StallD  out  1  hold Fetch_Decode register.
- FlushD  out  1  clear Fetch_Decode register.
- FlushE  out  1  clear Decode_Execute register (bubble).
- FlushM  out  1  clear Execute_Memory register.
- ForwardAE  out  2  SrcA select: 00 = RD1, 01 = W result, 10 = ALUResultM.
- ForwardBE  out  2  SrcB/WriteData select, same encoding.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Shadow entries: D holds {vld}. E holds {vld, rw, m2r, dst, rs, rt}. M holds {vld, rw, m2r, dst}. W holds {vld, rw, dst}.
- dstD = RegDstD ? RdD : RtD.
- Reset: every entry vld = 0, other fields 0. All outputs are 0 while rst is high and in the first cycle after reset.
- Each clock edge:
  - W <= M; M <= E (or invalid if FlushM).
  - E <= D fields, or invalid if FlushE.
  - D.vld <= 1, or 0 if FlushD; D.vld holds if StallD.
- Load-use (lu), combinational:
  - lu = D.vld & E.vld & E.m2r & E.rw & (E.dst != 0) & (E.dst == RsD | E.dst == RtD).
  - On lu: StallF = StallD = FlushE = 1 for exactly one cycle. The next cycle the load sits in M and lu falls unless a new load is in E.
- Branch taken (BranchTakenM=1): FlushD = FlushE = FlushM = 1 in the same cycle; StallF = StallD = 0.
  - Branch overrides lu. The wrong-path load-use instruction is discarded.
- Forwarding, A side:
  - ForwardAE = 10 if M.vld & M.rw & M.dst != 0 & M.dst == E.rs.
  - Else 01 if W.vld & W.rw & W.dst != 0 & W.dst == E.rs.
  - Else 00.
  - M has priority over W.
- Forwarding, B side: identical using E.rt.
- Register 0 never forwards and never stalls.
- Forwarding outputs are combinational from registered state, 0-cycle latency. Stall/flush outputs are combinational from state and D/M inputs.
- Writeback-to-D hazard is not handled here: the register file writes on the negedge, so it is resolved in the RF.
- Reset mid-operation: all entries are invalidated on the next edge; no stale forward survives.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- With the macro, extra outputs StallCount[CNT_W] and FlushCount[CNT_W]:
  - StallCount increments on every cycle with StallD = 1.
  - FlushCount increments on every cycle with BranchTakenM = 1.
  - Both saturate at all-ones, reset to 0 on rst.
- Without the macro, the ports and counters do not exist.

Decomposition:
- Shared package mips_pkg:
  - REG_ADDR_W.
  - Forward-select constants FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - Shadow-entry struct type.
- One natural sub-module: hazard_fwd_sel. Combinational compare of one source against the M/W entries, instantiated for rs and rt.

Test Plan:
- lw $2,0($0); add $3,$2,$4 -> one cycle StallF = StallD = FlushE = 1. The next cycle ForwardAE = 10 then 01 as appropriate, and $3 gets the correct sum.
- add $2,$1,$1; sub $5,$2,$2 -> no stall; ForwardAE = ForwardBE = 10 in sub's E cycle.
- add $2; nop; or $6,$2,$0 -> ForwardAE = 01 in or's E cycle.
- Both M and W write $7, E reads $7 -> ForwardAE = 10 (M priority).
- beq taken while a lw/use pair is in D/E -> FlushD = FlushE = FlushM = 1, StallD = 0; no wrong-path RegWrite reaches W.
- add $0,... followed by a dependent user of $0 -> Forward = 00, no stall.
- rst asserted mid-stream -> the next cycle all outputs are 0 and all entries invalid.
- With HAZARD_PERF_CNT_EN: 3 load-use events and 2 taken branches -> StallCount = 3, FlushCount = 2.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, forward-select codes and shadow-entry types for the hazard controller
package mips_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic                  vld;
      logic                  rw;
      logic                  m2r;
      logic [REG_ADDR_W-1:0] dst;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
   } e_entry_t;

   typedef struct packed {
      logic                  vld;
      logic                  rw;
      logic                  m2r;
      logic [REG_ADDR_W-1:0] dst;
   } m_entry_t;

   typedef struct packed {
      logic                  vld;
      logic                  rw;
      logic [REG_ADDR_W-1:0] dst;
   } w_entry_t;

   // Register 0 is hardwired, so a write to it is never a producer.
   function automatic logic writes_reg(input logic vld, input logic rw,
                                       input logic [REG_ADDR_W-1:0] dst);
      return vld & rw & (dst != '0);
   endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - forwarding select for one E-stage source against the M and W entries
module hazard_fwd_sel
   import mips_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] src,
   input  logic                  m_vld,
   input  logic                  m_rw,
   input  logic [REG_ADDR_W-1:0] m_dst,
   input  logic                  w_vld,
   input  logic                  w_rw,
   input  logic [REG_ADDR_W-1:0] w_dst,
   output logic [1:0]            sel
);

   // The younger M result wins over W when both target the same register.
   always_comb begin
      sel = FWD_RF;
      if (writes_reg(m_vld, m_rw, m_dst) && (m_dst == src)) begin
         sel = FWD_MEM;
      end else if (writes_reg(w_vld, w_rw, w_dst) && (w_dst == src)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - 5-stage pipeline hazard sequencer; HAZARD_PERF_CNT_EN adds stall/flush counters
module hazard_controller #(
   parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
`ifdef HAZARD_PERF_CNT_EN
  ,parameter int CNT_W      = 32
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] RsD,
   input  logic [REG_ADDR_W-1:0] RtD,
   input  logic [REG_ADDR_W-1:0] RdD,
   input  logic                  RegWriteD,
   input  logic                  MemtoRegD,
   input  logic                  RegDstD,
   input  logic                  BranchTakenM,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic                  FlushM,
   output logic [1:0]            ForwardAE,
   output logic [1:0]            ForwardBE
`ifdef HAZARD_PERF_CNT_EN
  ,output logic [CNT_W-1:0]      StallCount,
   output logic [CNT_W-1:0]      FlushCount
`endif
);

   import mips_pkg::*;

   logic                  d_vld;
   e_entry_t              e_q;
   m_entry_t              m_q;
   w_entry_t              w_q;
   logic [REG_ADDR_W-1:0] dst_d;
   logic                  load_use;
   logic [1:0]            fwd_a;
   logic [1:0]            fwd_b;
   logic                  unused_m2r;

   assign dst_d      = RegDstD ? RdD : RtD;
   assign unused_m2r = m_q.m2r;

   assign load_use = d_vld & e_q.vld & e_q.m2r & e_q.rw & (e_q.dst != '0) &
                     ((e_q.dst == RsD) | (e_q.dst == RtD));

   // A taken branch discards the D/E instructions, so it overrides any load-use stall.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushM = 1'b0;
      if (!rst) begin
         if (BranchTakenM) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
         end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   hazard_fwd_sel u_fwd_a (
      .src   (e_q.rs),
      .m_vld (m_q.vld),
      .m_rw  (m_q.rw),
      .m_dst (m_q.dst),
      .w_vld (w_q.vld),
      .w_rw  (w_q.rw),
      .w_dst (w_q.dst),
      .sel   (fwd_a)
   );

   hazard_fwd_sel u_fwd_b (
      .src   (e_q.rt),
      .m_vld (m_q.vld),
      .m_rw  (m_q.rw),
      .m_dst (m_q.dst),
      .w_vld (w_q.vld),
      .w_rw  (w_q.rw),
      .w_dst (w_q.dst),
      .sel   (fwd_b)
   );

   assign ForwardAE = rst ? FWD_RF : fwd_a;
   assign ForwardBE = rst ? FWD_RF : fwd_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         d_vld <= 1'b0;
         e_q   <= '0;
         m_q   <= '0;
         w_q   <= '0;
      end else begin
         w_q <= '{vld: m_q.vld, rw: m_q.rw, dst: m_q.dst};
         if (FlushM) begin
            m_q <= '0;
         end else begin
            m_q <= '{vld: e_q.vld, rw: e_q.rw, m2r: e_q.m2r, dst: e_q.dst};
         end
         if (FlushE) begin
            e_q <= '0;
         end else begin
            e_q <= '{vld: d_vld, rw: RegWriteD, m2r: MemtoRegD,
                     dst: dst_d, rs: RsD, rt: RtD};
         end
         if (FlushD) begin
            d_vld <= 1'b0;
         end else if (!StallD) begin
            d_vld <= 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (StallD && (StallCount != '1)) begin
            StallCount <= StallCount + CNT_W'(1);
         end
         if (BranchTakenM && (FlushCount != '1)) begin
            FlushCount <= FlushCount + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - scripted instruction stream with a queue of hand-derived expected controls
module tb_hazard_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] RsD, RtD, RdD;
   logic       RegWriteD, MemtoRegD, RegDstD, BranchTakenM;
   logic       StallF, StallD, FlushD, FlushE, FlushM;
   logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] StallCount, FlushCount;
`endif

   always #5 clk = ~clk;

   hazard_controller dut (
      .clk          (clk),
      .rst          (rst),
      .RsD          (RsD),
      .RtD          (RtD),
      .RdD          (RdD),
      .RegWriteD    (RegWriteD),
      .MemtoRegD    (MemtoRegD),
      .RegDstD      (RegDstD),
      .BranchTakenM (BranchTakenM),
      .StallF       (StallF),
      .StallD       (StallD),
      .FlushD       (FlushD),
      .FlushE       (FlushE),
      .FlushM       (FlushM),
      .ForwardAE    (ForwardAE),
      .ForwardBE    (ForwardBE)
`ifdef HAZARD_PERF_CNT_EN
     ,.StallCount   (StallCount),
      .FlushCount   (FlushCount)
`endif
   );

   // ctl = {StallF, StallD, FlushD, FlushE, FlushM}
   localparam logic [4:0] Z = 5'b00000;
   localparam logic [4:0] S = 5'b11010;
   localparam logic [4:0] B = 5'b00111;

   typedef struct {
      logic       rst;
      logic       br;
      logic [4:0] rs, rt, rd;
      logic       rw, m2r, rdst;
      logic [4:0] ctl;
      logic [1:0] fa, fb;
   } step_t;

   typedef struct {
      int         idx;
      logic [4:0] ctl;
      logic [1:0] fa, fb;
   } exp_t;

   step_t steps[$];
   exp_t  exp_q[$];
   int    checks   = 0;
   int    failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic add_step(input logic r, input logic br, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic rw, input logic m2r, input logic rdst,
                           input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
      steps.push_back('{rst: r, br: br, rs: rs, rt: rt, rd: rd, rw: rw, m2r: m2r, rdst: rdst,
                        ctl: ctl, fa: fa, fb: fb});
   endtask

   task automatic rtype(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t, input logic br,
                        input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
      add_step(1'b0, br, s, t, d, 1'b1, 1'b0, 1'b1, ctl, fa, fb);
   endtask

   task automatic lw(input logic [4:0] t, input logic [4:0] s,
                     input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
      add_step(1'b0, 1'b0, s, t, 5'd0, 1'b1, 1'b1, 1'b0, ctl, fa, fb);
   endtask

   task automatic beq(input logic [4:0] s, input logic [4:0] t, input logic br, input logic [4:0] ctl);
      add_step(1'b0, br, s, t, 5'd0, 1'b0, 1'b0, 1'b0, ctl, 2'b00, 2'b00);
   endtask

   task automatic nop(input logic br, input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
      add_step(1'b0, br, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ctl, fa, fb);
   endtask

   task automatic rst_step();
      add_step(1'b1, 1'b1, 5'd0, 5'd17, 5'd0, 1'b1, 1'b1, 1'b0, Z, 2'b00, 2'b00);
   endtask

   initial begin
      rst_step(); rst_step();
      nop(0, Z, 2'b00, 2'b00);               // first cycle after reset
      lw(2, 0, Z, 2'b00, 2'b00);             // lw $2,0($0)
      rtype(3, 2, 4, 0, S, 2'b00, 2'b00);    // add $3,$2,$4 -> load-use
      rtype(3, 2, 4, 0, Z, 2'b00, 2'b00);    // held in D
      nop(0, Z, 2'b01, 2'b00);               // add in E gets load from W
      rtype(2, 1, 1, 0, Z, 2'b00, 2'b00);
      rtype(5, 2, 2, 0, Z, 2'b00, 2'b00);
      nop(0, Z, 2'b10, 2'b10);               // sub in E: both from M
      rtype(2, 1, 1, 0, Z, 2'b00, 2'b00);
      nop(0, Z, 2'b00, 2'b00);
      rtype(6, 2, 0, 0, Z, 2'b00, 2'b00);
      nop(0, Z, 2'b01, 2'b00);               // or in E: $2 from W
      rtype(7, 1, 1, 0, Z, 2'b00, 2'b00);
      rtype(7, 2, 2, 0, Z, 2'b00, 2'b00);
      rtype(8, 7, 7, 0, Z, 2'b00, 2'b00);
      nop(0, Z, 2'b10, 2'b10);               // $7 in M and W -> M wins
      rtype(0, 1, 1, 0, Z, 2'b00, 2'b00);
      rtype(9, 0, 0, 0, Z, 2'b00, 2'b00);
      nop(0, Z, 2'b00, 2'b00);               // $0 in M never forwards
      lw(0, 1, Z, 2'b00, 2'b00);
      rtype(10, 0, 0, 0, Z, 2'b00, 2'b00);   // load to $0 never stalls
      nop(0, Z, 2'b00, 2'b00);
      beq(1, 1, 0, Z);
      lw(11, 0, Z, 2'b00, 2'b00);
      rtype(12, 11, 11, 1, B, 2'b00, 2'b00); // branch overrides load-use
      nop(0, Z, 2'b00, 2'b00);
      rtype(14, 11, 12, 0, Z, 2'b00, 2'b00);
      nop(0, Z, 2'b00, 2'b00);               // flushed lw must not forward $11
      rtype(15, 1, 1, 0, Z, 2'b00, 2'b00);
      rtype(16, 15, 15, 0, Z, 2'b00, 2'b00);
      rst_step();                            // mid-stream reset
      rtype(18, 17, 17, 0, Z, 2'b00, 2'b00);
      nop(0, Z, 2'b00, 2'b00);
      lw(20, 0, Z, 2'b00, 2'b00);
      rtype(21, 20, 0, 0, S, 2'b00, 2'b00);
      rtype(21, 20, 0, 0, Z, 2'b00, 2'b00);
      lw(20, 0, Z, 2'b01, 2'b00);
      rtype(21, 20, 0, 0, S, 2'b00, 2'b00);
      rtype(21, 20, 0, 0, Z, 2'b00, 2'b00);
      lw(20, 0, Z, 2'b01, 2'b00);
      rtype(21, 20, 0, 0, S, 2'b00, 2'b00);
      rtype(21, 20, 0, 0, Z, 2'b00, 2'b00);
      nop(0, Z, 2'b01, 2'b00);
      nop(1, B, 2'b00, 2'b00);
      nop(0, Z, 2'b00, 2'b00);
      nop(1, B, 2'b00, 2'b00);
      nop(0, Z, 2'b00, 2'b00);

      for (int i = 0; i < steps.size(); i++) begin
         exp_t e;
         rst          = steps[i].rst;
         BranchTakenM = steps[i].br;
         RsD          = steps[i].rs;
         RtD          = steps[i].rt;
         RdD          = steps[i].rd;
         RegWriteD    = steps[i].rw;
         MemtoRegD    = steps[i].m2r;
         RegDstD      = steps[i].rdst;
         exp_q.push_back('{idx: i, ctl: steps[i].ctl, fa: steps[i].fa, fb: steps[i].fb});
         @(negedge clk);
         e = exp_q.pop_front();
         check_eq($sformatf("ctl[%0d]", e.idx), 32'({StallF, StallD, FlushD, FlushE, FlushM}), 32'(e.ctl));
         check_eq($sformatf("fa[%0d]", e.idx), 32'(ForwardAE), 32'(e.fa));
         check_eq($sformatf("fb[%0d]", e.idx), 32'(ForwardBE), 32'(e.fb));
         @(posedge clk);
         #1;
      end

`ifdef HAZARD_PERF_CNT_EN
      check_eq("stall_count", StallCount, 32'd3);
      check_eq("flush_count", FlushCount, 32'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
